redmule_tile_sequencer: RTL and testbench

- Sequences the RedMulE engine over a tiled GEMM job: walks the M/N/K tile space and issues one tile descriptor per tile over a valid/ready handshake.
- Tracks outstanding Z-tile stores and signals job completion only after every Z store has been acknowledged.
- Sits between the controller FSM (start/done) and the streamer/scheduler (tile consumers).

---
 rtl/redmule_tile_sequencer.sv | 147 ++++++++++++++
 tb/tb_redmule_tile_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/redmule_tile_sequencer.sv
// Tile sequencer for the RedMulE GEMM engine: walks the M/N/K tile space, issues one
// descriptor per tile and holds job completion until every Z-tile store is acknowledged.
module redmule_tile_sequencer #(
   parameter  int unsigned CntWidth   = 16,
   parameter  int unsigned MaxOutst   = 2,
   localparam int unsigned OutstWidth = $clog2(MaxOutst + 1)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                clear_i,
   input  logic                start_i,
   input  logic [CntWidth-1:0] m_tiles_i,
   input  logic [CntWidth-1:0] n_tiles_i,
   input  logic [CntWidth-1:0] k_tiles_i,
   output logic                tile_valid_o,
   input  logic                tile_ready_i,
   output logic [CntWidth-1:0] m_idx_o,
   output logic [CntWidth-1:0] n_idx_o,
   output logic [CntWidth-1:0] k_idx_o,
   output logic                first_k_o,
   output logic                last_k_o,
   output logic                last_tile_o,
   input  logic                z_done_i,
   output logic                busy_o,
   output logic                done_o,
   output logic                err_o
);

   localparam logic [OutstWidth-1:0] OutstMax = OutstWidth'(MaxOutst);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

   state_e                state_reg, state_next;
   logic [CntWidth-1:0]   m_tiles_reg, n_tiles_reg, k_tiles_reg;
   logic [CntWidth-1:0]   m_idx_reg, n_idx_reg, k_idx_reg;
   logic [OutstWidth-1:0] outst_reg, outst_next;
   logic                  err_reg;

   logic k_last, n_last, m_last, tile_last;
   logic stall, valid_int, xfer, outst_inc, outst_dec, err_set, any_zero;

   assign k_last    = (k_idx_reg == k_tiles_reg - CntWidth'(1));
   assign n_last    = (n_idx_reg == n_tiles_reg - CntWidth'(1));
   assign m_last    = (m_idx_reg == m_tiles_reg - CntWidth'(1));
   assign tile_last = k_last && n_last && m_last;
   assign any_zero  = (m_tiles_i == '0) || (n_tiles_i == '0) || (k_tiles_i == '0);

   // A Z-producing tile may only go out when a store slot is free.
   assign stall     = k_last && (outst_reg == OutstMax);
   assign valid_int = (state_reg == ISSUE) && !stall;
   assign xfer      = valid_int && tile_ready_i;
   assign outst_inc = xfer && k_last;
   assign outst_dec = z_done_i;
   assign err_set   = outst_dec && !outst_inc && (outst_reg == '0);

   always_comb begin
      outst_next = outst_reg;
      if (outst_inc && !outst_dec) begin
         outst_next = outst_reg + OutstWidth'(1);
      end else if (outst_dec && !outst_inc && (outst_reg != '0)) begin
         outst_next = outst_reg - OutstWidth'(1);
      end
   end

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE:  if (start_i) state_next = any_zero ? DONE : ISSUE;
         ISSUE: if (xfer && tile_last) state_next = DRAIN;
         DRAIN: if (outst_next == '0) state_next = DONE;
         DONE:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (clear_i) state_next = IDLE;
   end

   // Output logic; tile flags are only meaningful while issuing, so they stay low elsewhere.
   always_comb begin
      tile_valid_o = valid_int;
      busy_o       = (state_reg == ISSUE) || (state_reg == DRAIN);
      done_o       = (state_reg == DONE);
      first_k_o    = (state_reg == ISSUE) && (k_idx_reg == '0);
      last_k_o     = (state_reg == ISSUE) && k_last;
      last_tile_o  = (state_reg == ISSUE) && tile_last;
      m_idx_o      = m_idx_reg;
      n_idx_o      = n_idx_reg;
      k_idx_o      = k_idx_reg;
      err_o        = err_reg;
   end

   // Job sizes, loop indices, store accounting
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         m_tiles_reg <= '0;
         n_tiles_reg <= '0;
         k_tiles_reg <= '0;
         m_idx_reg   <= '0;
         n_idx_reg   <= '0;
         k_idx_reg   <= '0;
         outst_reg   <= '0;
         err_reg     <= 1'b0;
      end else if (clear_i) begin
         m_tiles_reg <= '0;
         n_tiles_reg <= '0;
         k_tiles_reg <= '0;
         m_idx_reg   <= '0;
         n_idx_reg   <= '0;
         k_idx_reg   <= '0;
         outst_reg   <= '0;
         err_reg     <= 1'b0;
      end else begin
         if ((state_reg == IDLE) && start_i) begin
            m_tiles_reg <= m_tiles_i;
            n_tiles_reg <= n_tiles_i;
            k_tiles_reg <= k_tiles_i;
            m_idx_reg   <= '0;
            n_idx_reg   <= '0;
            k_idx_reg   <= '0;
         end else if (xfer && !tile_last) begin
            if (k_last) begin
               k_idx_reg <= '0;
               if (n_last) begin
                  n_idx_reg <= '0;
                  m_idx_reg <= m_idx_reg + CntWidth'(1);
               end else begin
                  n_idx_reg <= n_idx_reg + CntWidth'(1);
               end
            end else begin
               k_idx_reg <= k_idx_reg + CntWidth'(1);
            end
         end
         outst_reg <= outst_next;
         if (err_set) err_reg <= 1'b1;
      end
   end

endmodule

// File: tb/tb_redmule_tile_sequencer.sv
// Directed bench for redmule_tile_sequencer: loop order, store throttling, backpressure,
// empty jobs, coincident events and clear.
module tb_redmule_tile_sequencer;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        clear_i;
   logic        start_i;
   logic [15:0] m_tiles_i, n_tiles_i, k_tiles_i;
   logic        tile_valid_o;
   logic        tile_ready_i;
   logic [15:0] m_idx_o, n_idx_o, k_idx_o;
   logic        first_k_o, last_k_o, last_tile_o;
   logic        z_done_i;
   logic        busy_o, done_o, err_o;

   int n_checks = 0;
   int n_fail   = 0;

   redmule_tile_sequencer #(.CntWidth(16), .MaxOutst(2)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .clear_i      (clear_i),
      .start_i      (start_i),
      .m_tiles_i    (m_tiles_i),
      .n_tiles_i    (n_tiles_i),
      .k_tiles_i    (k_tiles_i),
      .tile_valid_o (tile_valid_o),
      .tile_ready_i (tile_ready_i),
      .m_idx_o      (m_idx_o),
      .n_idx_o      (n_idx_o),
      .k_idx_o      (k_idx_o),
      .first_k_o    (first_k_o),
      .last_k_o     (last_k_o),
      .last_tile_o  (last_tile_o),
      .z_done_i     (z_done_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .err_o        (err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic start_job(input int m, input int n, input int k);
      m_tiles_i = 16'(m);
      n_tiles_i = 16'(n);
      k_tiles_i = 16'(k);
      start_i   = 1'b1;
      tick();
      start_i   = 1'b0;
   endtask

   task automatic test_reset();
      n_checks++;
      if ({tile_valid_o, busy_o, done_o, err_o, first_k_o, last_k_o, last_tile_o} !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_flags got v%b b%b d%b e%b f%b l%b t%b want all 0", tile_valid_o,
                  busy_o, done_o, err_o, first_k_o, last_k_o, last_tile_o);
      end
      n_checks++;
      if ({m_idx_o, n_idx_o, k_idx_o} !== 48'd0) begin
         n_fail++;
         $display("FAIL reset_idx got %0d,%0d,%0d want 0,0,0", m_idx_o, n_idx_o, k_idx_o);
      end
   endtask

   task automatic test_basic();
      int em = 0, en = 0, ek = 0, xfers = 0, acks = 0, dones = 0, post = 0;
      logic [1:0] zp = 2'b00;
      logic lk_exp, lt_exp, fk_exp, xf;
      tile_ready_i = 1'b1;
      start_job(2, 2, 3);
      for (int c = 0; c < 200 && post < 3; c++) begin
         z_done_i = zp[1];
         if (z_done_i) acks++;
         xf = tile_valid_o & tile_ready_i;
         lk_exp = (ek == 2);
         fk_exp = (ek == 0);
         lt_exp = (em == 1) && (en == 1) && (ek == 2);
         if (xf) begin
            n_checks++;
            if ({m_idx_o, n_idx_o, k_idx_o} !== {16'(em), 16'(en), 16'(ek)}) begin
               n_fail++;
               $display("FAIL basic_idx got %0d,%0d,%0d want %0d,%0d,%0d", m_idx_o, n_idx_o,
                        k_idx_o, em, en, ek);
            end
            n_checks++;
            if ({first_k_o, last_k_o, last_tile_o} !== {fk_exp, lk_exp, lt_exp}) begin
               n_fail++;
               $display("FAIL basic_flags at %0d,%0d,%0d got f%b l%b t%b want f%b l%b t%b", em,
                        en, ek, first_k_o, last_k_o, last_tile_o, fk_exp, lk_exp, lt_exp);
            end
            xfers++;
            if (ek == 2) begin
               ek = 0;
               if (en == 1) begin en = 0; em++; end else en++;
            end else ek++;
         end
         if (done_o) begin
            dones++;
            n_checks++;
            if (acks != 4) begin
               n_fail++;
               $display("FAIL basic_done_acks got %0d acks at done want 4", acks);
            end
         end
         if (dones > 0) post++;
         zp = {zp[0], xf & lk_exp};
         tick();
      end
      z_done_i = 1'b0;
      n_checks++;
      if (xfers != 12 || dones != 1) begin
         n_fail++;
         $display("FAIL basic_totals got %0d xfers %0d dones want 12 xfers 1 done", xfers, dones);
      end
      n_checks++;
      if ({err_o, busy_o} !== 2'b00) begin
         n_fail++;
         $display("FAIL basic_end got err %b busy %b want 0 0", err_o, busy_o);
      end
   endtask

   task automatic test_stall();
      tile_ready_i = 1'b1;
      z_done_i     = 1'b0;
      start_job(1, 3, 1);
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (tile_valid_o !== 1'b1 || n_idx_o !== 16'(i)) begin
            n_fail++;
            $display("FAIL stall_issue%0d got valid %b n %0d want valid 1 n %0d", i, tile_valid_o,
                     n_idx_o, i);
         end
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (tile_valid_o !== 1'b0 || {m_idx_o, n_idx_o, k_idx_o} !== {16'd0, 16'd2, 16'd0}
             || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_hold got valid %b idx %0d,%0d,%0d busy %b want 0 (0,2,0) 1",
                     tile_valid_o, m_idx_o, n_idx_o, k_idx_o, busy_o);
         end
         tick();
      end
      z_done_i = 1'b1;
      tick();
      z_done_i = 1'b0;
      n_checks++;
      if (tile_valid_o !== 1'b1 || last_tile_o !== 1'b1 || n_idx_o !== 16'd2) begin
         n_fail++;
         $display("FAIL stall_release got valid %b last_tile %b n %0d want 1 1 2", tile_valid_o,
                  last_tile_o, n_idx_o);
      end
      tick();
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (tile_valid_o !== 1'b0 || busy_o !== 1'b1 || done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_drain%0d got valid %b busy %b done %b want 0 1 0", i,
                     tile_valid_o, busy_o, done_o);
         end
         z_done_i = 1'b1;
         tick();
         z_done_i = 1'b0;
      end
      n_checks++;
      if (done_o !== 1'b1 || busy_o !== 1'b0 || err_o !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_done got done %b busy %b err %b want 1 0 0", done_o, busy_o, err_o);
      end
      tick();
   endtask

   task automatic test_backpressure();
      int em = 0, en = 0, ek = 0, xfers = 0, pending = 0, dones = 0, post = 0;
      logic xf, lk_exp;
      start_job(2, 2, 2);
      for (int c = 0; c < 400 && post < 2; c++) begin
         tile_ready_i = 1'($urandom_range(0, 1));
         z_done_i     = (pending > 0) && ($urandom_range(0, 1) == 1);
         lk_exp       = (ek == 1);
         if (tile_valid_o) begin
            n_checks++;
            if ({m_idx_o, n_idx_o, k_idx_o} !== {16'(em), 16'(en), 16'(ek)}) begin
               n_fail++;
               $display("FAIL bp_desc got %0d,%0d,%0d want %0d,%0d,%0d", m_idx_o, n_idx_o,
                        k_idx_o, em, en, ek);
            end
         end
         xf = tile_valid_o & tile_ready_i;
         if (xf) begin
            xfers++;
            if (ek == 1) begin
               ek = 0;
               if (en == 1) begin en = 0; em++; end else en++;
            end else ek++;
         end
         pending = pending + ((xf && lk_exp) ? 1 : 0) - (z_done_i ? 1 : 0);
         if (done_o) dones++;
         if (dones > 0) post++;
         tick();
      end
      z_done_i     = 1'b0;
      tile_ready_i = 1'b1;
      n_checks++;
      if (xfers != 8 || dones != 1 || err_o !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_totals got %0d xfers %0d dones err %b want 8 1 0", xfers, dones, err_o);
      end
   endtask

   task automatic test_k_zero();
      start_job(3, 2, 0);
      n_checks++;
      if (done_o !== 1'b1 || tile_valid_o !== 1'b0 || busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL kzero_done got done %b valid %b busy %b want 1 0 0", done_o,
                  tile_valid_o, busy_o);
      end
      tick();
      n_checks++;
      if (done_o !== 1'b0 || tile_valid_o !== 1'b0 || busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL kzero_after got done %b valid %b busy %b want 0 0 0", done_o,
                  tile_valid_o, busy_o);
      end
   endtask

   task automatic test_simultaneous();
      tile_ready_i = 1'b1;
      z_done_i     = 1'b0;
      start_job(1, 2, 1);
      tick();
      z_done_i = 1'b1;
      n_checks++;
      if (tile_valid_o !== 1'b1 || last_tile_o !== 1'b1) begin
         n_fail++;
         $display("FAIL simul_last got valid %b last_tile %b want 1 1", tile_valid_o, last_tile_o);
      end
      tick();
      z_done_i = 1'b0;
      tick();
      n_checks++;
      if (busy_o !== 1'b1 || done_o !== 1'b0) begin
         n_fail++;
         $display("FAIL simul_outst got busy %b done %b want 1 0 (one store still open)", busy_o,
                  done_o);
      end
      z_done_i = 1'b1;
      tick();
      z_done_i = 1'b0;
      n_checks++;
      if (done_o !== 1'b1 || err_o !== 1'b0) begin
         n_fail++;
         $display("FAIL simul_done got done %b err %b want 1 0", done_o, err_o);
      end
      tick();
      z_done_i = 1'b1;
      tick();
      z_done_i = 1'b0;
      tick();
      tick();
      n_checks++;
      if (err_o !== 1'b1) begin
         n_fail++;
         $display("FAIL idle_err got err %b want 1", err_o);
      end
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      n_checks++;
      if (err_o !== 1'b0) begin
         n_fail++;
         $display("FAIL clear_err got err %b want 0", err_o);
      end
   endtask

   task automatic test_clear();
      tile_ready_i = 1'b1;
      z_done_i     = 1'b0;
      start_job(2, 2, 2);
      tick();
      tick();
      tick();
      n_checks++;
      if ({m_idx_o, n_idx_o, k_idx_o} !== {16'd0, 16'd1, 16'd1} || tile_valid_o !== 1'b1) begin
         n_fail++;
         $display("FAIL clear_pre got %0d,%0d,%0d valid %b want 0,1,1 valid 1", m_idx_o,
                  n_idx_o, k_idx_o, tile_valid_o);
      end
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if ({tile_valid_o, busy_o, done_o, err_o, first_k_o, last_k_o, last_tile_o} !== 7'b0 ||
             {m_idx_o, n_idx_o, k_idx_o} !== 48'd0) begin
            n_fail++;
            $display("FAIL clear_idle%0d got v%b b%b d%b idx %0d,%0d,%0d want all 0", i,
                     tile_valid_o, busy_o, done_o, m_idx_o, n_idx_o, k_idx_o);
         end
         tick();
      end
      tile_ready_i = 1'b0;
      start_job(2, 2, 2);
      n_checks++;
      if ({m_idx_o, n_idx_o, k_idx_o} !== 48'd0 || tile_valid_o !== 1'b1 || first_k_o !== 1'b1) begin
         n_fail++;
         $display("FAIL clear_restart got %0d,%0d,%0d valid %b first_k %b want 0,0,0 1 1",
                  m_idx_o, n_idx_o, k_idx_o, tile_valid_o, first_k_o);
      end
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
   endtask

   initial begin
      rst_ni       = 1'b0;
      clear_i      = 1'b0;
      start_i      = 1'b0;
      tile_ready_i = 1'b0;
      z_done_i     = 1'b0;
      m_tiles_i    = '0;
      n_tiles_i    = '0;
      k_tiles_i    = '0;
      tick();
      tick();
      rst_ni = 1'b1;
      tick();
      test_reset();
      test_basic();
      test_stall();
      test_backpressure();
      test_k_zero();
      test_simultaneous();
      test_clear();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
